keypad_encoder: RTL and testbench

KEYPAD_ENCODER -- requirements
Module: keypad_encoder

---
 rtl/keypad_encoder.sv | 234 +++++++++++++++++++++++
 tb/tb_keypad_encoder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_encoder.sv
// -----------------------------------------------------------------------------
// keypad_encoder
//
// Scans a 4x4 active-low matrix keypad one row at a time, debounces the first
// key found, and reports it as a class bit (tipo) plus a 4-bit code (number).
// While a key is accepted the scan is frozen on its row, and only its own
// column is watched until a debounced release returns the scan to row 0.
//
// Parameters
//   SCAN_DIV         clk cycles each row is driven per scan slot (>= 3)
//   DEBOUNCE_CYCLES  consecutive stable cycles needed for press and release
//
// Ports
//   clk        in   system clock, everything on posedge
//   reset      in   synchronous, active-high reset
//   col[3:0]   in   keypad columns, active-low, asynchronous to clk
//   row[3:0]   out  row drive, active-low, exactly one bit low
//   tipo       out  0 = digit key, 1 = sign/command key
//   number     out  key code of the last accepted key
//   key_valid  out  one-cycle pulse per accepted press
//   key_down   out  high while the accepted key is held (incl. release debounce)
// -----------------------------------------------------------------------------
module keypad_encoder #(
   parameter int SCAN_DIV        = 4,
   parameter int DEBOUNCE_CYCLES = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] col,
   output logic [3:0] row,
   output logic       tipo,
   output logic [3:0] number,
   output logic       key_valid,
   output logic       key_down
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_SCAN,
      S_DEB_PRESS,
      S_PRESSED,
      S_HOLD,
      S_DEB_RELEASE
   } state_t;

   state_t        state_q,   state_d;
   logic [1:0]    row_idx_q, row_idx_d;
   logic [1:0]    col_idx_q, col_idx_d;
   logic [SW-1:0] slot_q,    slot_d;
   logic [DW-1:0] deb_q,     deb_d;
   logic          tipo_q,    tipo_d;
   logic [3:0]    number_q,  number_d;

   logic [3:0]    col_meta_q, col_sync_q;
   logic [1:0]    low_idx;
   logic          any_low;
   logic          sel_low;
   logic          key_tipo;
   logic [3:0]    key_num;

   // -------------------------------------------------------------------------
   // Column synchronizer. Resetting to all-ones makes the keypad look idle
   // until real samples have propagated through both flops.
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge value of its neighbours; blocking here would collapse the chain.
   always_ff @(posedge clk) begin
      if (reset) begin
         col_meta_q <= 4'hF;
         col_sync_q <= 4'hF;
      end else begin
         col_meta_q <= col;
         col_sync_q <= col_meta_q;
      end
   end

   // Lowest-index low column of the synchronized sample.
   always_comb begin
      low_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!col_sync_q[i]) low_idx = 2'(i);
      end
   end

   assign any_low = (col_sync_q != 4'hF);
   assign sel_low = ~col_sync_q[col_idx_q];

   // -------------------------------------------------------------------------
   // Key map for the latched (row, col). Digits 1..9 fill rows 0..2 of
   // columns 0..2 as row*3+col+1; column 3 holds + - = as codes A, B, C.
   // Row 3 reads C, 0, X1, X2.
   // -------------------------------------------------------------------------
   always_comb begin
      key_tipo = 1'b1;
      key_num  = 4'h0;
      if (row_idx_q != 2'd3) begin
         if (col_idx_q == 2'd3) begin
            key_num = 4'hA + {2'b00, row_idx_q};
         end else begin
            key_tipo = 1'b0;
            key_num  = ({2'b00, row_idx_q} * 4'd3) + {2'b00, col_idx_q} + 4'd1;
         end
      end else begin
         case (col_idx_q)
            2'd0:    key_num = 4'hF;
            2'd1:    begin key_tipo = 1'b0; key_num = 4'h0; end
            2'd2:    key_num = 4'hD;
            default: key_num = 4'hE;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_SCAN;
         row_idx_q <= 2'd0;
         col_idx_q <= 2'd0;
         slot_q    <= '0;
         deb_q     <= '0;
         tipo_q    <= 1'b0;
         number_q  <= 4'h0;
      end else begin
         state_q   <= state_d;
         row_idx_q <= row_idx_d;
         col_idx_q <= col_idx_d;
         slot_q    <= slot_d;
         deb_q     <= deb_d;
         tipo_q    <= tipo_d;
         number_q  <= number_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next state and Moore outputs
   // -------------------------------------------------------------------------
   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned; a missing default would infer a latch.
   always_comb begin
      state_d   = state_q;
      row_idx_d = row_idx_q;
      col_idx_d = col_idx_q;
      slot_d    = slot_q;
      deb_d     = deb_q;
      tipo_d    = tipo_q;
      number_d  = number_q;
      key_valid = 1'b0;
      key_down  = 1'b0;

      case (state_q)
         S_SCAN: begin
            // The sample is taken on the last slot cycle, when the
            // synchronizer output reflects the row currently driven.
            if (slot_q == SLOT_LAST) begin
               slot_d = '0;
               if (any_low) begin
                  col_idx_d = low_idx;
                  deb_d     = '0;
                  state_d   = S_DEB_PRESS;
               end else begin
                  row_idx_d = row_idx_q + 2'd1;
               end
            end else begin
               slot_d = slot_q + SW'(1);
            end
         end

         S_DEB_PRESS: begin
            if (sel_low) begin
               if (deb_q == DEB_LAST) begin
                  deb_d    = '0;
                  tipo_d   = key_tipo;
                  number_d = key_num;
                  state_d  = S_PRESSED;
               end else begin
                  deb_d = deb_q + DW'(1);
               end
            end else begin
               // Bounce or glitch: give up and carry on scanning.
               deb_d     = '0;
               row_idx_d = row_idx_q + 2'd1;
               slot_d    = '0;
               state_d   = S_SCAN;
            end
         end

         S_PRESSED: begin
            key_valid = 1'b1;
            key_down  = 1'b1;
            state_d   = S_HOLD;
         end

         S_HOLD: begin
            key_down = 1'b1;
            if (!sel_low) begin
               deb_d   = '0;
               state_d = S_DEB_RELEASE;
            end
         end

         S_DEB_RELEASE: begin
            key_down = 1'b1;
            if (!sel_low) begin
               if (deb_q == DEB_LAST) begin
                  deb_d     = '0;
                  row_idx_d = 2'd0;
                  slot_d    = '0;
                  state_d   = S_SCAN;
               end else begin
                  deb_d = deb_q + DW'(1);
               end
            end else begin
               deb_d   = '0;
               state_d = S_HOLD;
            end
         end

         default: begin
            state_d = S_SCAN;
         end
      endcase
   end

   assign row    = ~(4'b0001 << row_idx_q);
   assign tipo   = tipo_q;
   assign number = number_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// -----------------------------------------------------------------------------
// tb_keypad_encoder
//
// Drives a simulated 4x4 keypad (a 16-bit pressed-key matrix resolved against
// the DUT's row drive) and compares every output on every cycle against a
// behavioural model of the keypad rules. Directed scenarios cover the listed
// press, bounce, multi-key, glitch and reset cases; a randomized section
// follows.
// -----------------------------------------------------------------------------
module tb_keypad_encoder;

   localparam int SD = 4;
   localparam int DB = 8;

   logic       clk;
   logic       reset;
   logic [3:0] col;
   logic [3:0] row;
   logic       tipo;
   logic [3:0] number;
   logic       key_valid;
   logic       key_down;

   logic [15:0] keys;        // keys[r*4+c] = 1 while key (r,c) is pressed
   int          n_tests = 0;
   int          n_fail  = 0;
   int          pulses  = 0;
   logic [4:0]  last_code = 5'd0;
   logic        prev_kv = 1'b0;

   keypad_encoder #(
      .SCAN_DIV       (SD),
      .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .col      (col),
      .row      (row),
      .tipo     (tipo),
      .number   (number),
      .key_valid(key_valid),
      .key_down (key_down)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Physical keypad: a column is pulled low by any pressed key whose row is
   // currently driven low.
   function automatic logic [3:0] col_of(input logic [3:0] rv, input logic [15:0] k);
      logic [3:0] c;
      c = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int cc = 0; cc < 4; cc++)
            if (rv[r] === 1'b0 && k[r*4+cc]) c[cc] = 1'b0;
      return c;
   endfunction

   assign col = col_of(row, keys);

   // {tipo, number} for key index r*4+c, taken from the printed key legends.
   function automatic logic [4:0] key_code(input int k);
      string legend;
      byte   ch;
      legend = "123+456-789=C0XY";   // X = X1, Y = X2
      ch = legend[k];
      if (ch >= "0" && ch <= "9") return {1'b0, 4'(ch - "0")};
      if (ch == "+") return 5'b1_1010;
      if (ch == "-") return 5'b1_1011;
      if (ch == "=") return 5'b1_1100;
      if (ch == "C") return 5'b1_1111;
      if (ch == "X") return 5'b1_1101;
      return 5'b1_1110;
   endfunction

   // ------------------------------------------------------------------------
   // Reference model. Phases: 0 scanning, 1 confirming press, 2 accepted,
   // 3 holding, 4 confirming release.
   // ------------------------------------------------------------------------
   int         m_phase = 0, m_ri = 0, m_slot = 0, m_run = 0, m_lr = 0, m_lc = 0;
   logic [3:0] m_meta = 4'hF, m_sync = 4'hF;
   logic [4:0] m_code = 5'd0;

   function automatic logic [3:0] m_row();
      return ~(4'b0001 << m_ri);
   endfunction

   task automatic model_step(input logic rst, input logic [3:0] col_in);
      logic [3:0] cs;
      logic       low;
      if (rst) begin
         m_phase = 0; m_ri = 0; m_slot = 0; m_run = 0;
         m_meta = 4'hF; m_sync = 4'hF; m_code = 5'd0;
         return;
      end
      cs  = m_sync;
      low = !cs[m_lc];
      case (m_phase)
         0: begin
            if (m_slot == SD - 1) begin
               m_slot = 0;
               if (cs != 4'hF) begin
                  for (int c = 3; c >= 0; c--) if (!cs[c]) m_lc = c;
                  m_lr = m_ri; m_run = 0; m_phase = 1;
               end else m_ri = (m_ri + 1) % 4;
            end else m_slot++;
         end
         1: begin
            if (low) begin
               m_run++;
               if (m_run == DB) begin
                  m_code = key_code(m_lr * 4 + m_lc); m_run = 0; m_phase = 2;
               end
            end else begin
               m_run = 0; m_ri = (m_ri + 1) % 4; m_slot = 0; m_phase = 0;
            end
         end
         2: m_phase = 3;
         3: if (!low) begin m_run = 0; m_phase = 4; end
         default: begin
            if (!low) begin
               m_run++;
               if (m_run == DB) begin
                  m_run = 0; m_ri = 0; m_slot = 0; m_phase = 0;
               end
            end else begin
               m_run = 0; m_phase = 3;
            end
         end
      endcase
      m_sync = m_meta;
      m_meta = col_in;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare();
      logic [3:0] er;
      er = m_row();
      check("row",       32'(row),       32'(er));
      check("key_valid", 32'(key_valid), 32'(m_phase == 2));
      check("key_down",  32'(key_down),  32'(m_phase >= 2));
      check("tipo",      32'(tipo),      32'(m_code[4]));
      check("number",    32'(number),    32'(m_code[3:0]));
      check("kv_twice",  32'(key_valid & prev_kv), 32'd0);
      prev_kv = key_valid;
      if (key_valid === 1'b1) begin
         pulses++;
         last_code = {tipo, number};
      end
   endtask

   // One clock: inputs are final, model advances, DUT clocks, outputs compared.
   task automatic step();
      model_step(reset, col_of(m_row(), keys));
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   task automatic press_release(input int k, input int hold, input int gap);
      keys = '0; keys[k] = 1'b1;
      repeat (hold) step();
      keys = '0;
      repeat (gap) step();
   endtask

   initial begin
      int         found;
      logic [4:0] seq_codes [3];
      int         seq_keys  [3];

      keys  = '0;
      reset = 1'b1;
      repeat (3) step();
      check("rst_row",    32'(row),       32'h0000_000E);
      check("rst_kv",     32'(key_valid), 32'd0);
      check("rst_kd",     32'(key_down),  32'd0);
      check("rst_tipo",   32'(tipo),      32'd0);
      check("rst_number", 32'(number),    32'd0);
      reset = 1'b0;
      repeat (10) step();

      // Key 6 held 60 cycles.
      pulses = 0;
      press_release(6, 60, 40);
      check("k6_pulses", 32'(pulses),    32'd1);
      check("k6_code",   32'(last_code), 32'b0_0110);
      check("k6_down",   32'(key_down),  32'd0);

      // +, C, 0 in order.
      seq_keys  = '{3, 12, 13};
      seq_codes = '{5'b1_1010, 5'b1_1111, 5'b0_0000};
      for (int i = 0; i < 3; i++) begin
         pulses = 0;
         press_release(seq_keys[i], 50, 40);
         check("seq_pulses", 32'(pulses),    32'd1);
         check("seq_code",   32'(last_code), 32'(seq_codes[i]));
      end

      // Key 1 bouncing every 3 cycles for 24 cycles, then stable.
      pulses = 0;
      keys = '0;
      for (int i = 0; i < 8; i++) begin
         keys[0] = ~keys[0];
         repeat (3) step();
      end
      press_release(0, 60, 40);
      check("bounce_pulses", 32'(pulses),    32'd1);
      check("bounce_code",   32'(last_code), 32'b0_0001);

      // Keys 7 and 9 together; 9 released while 7 held.
      pulses = 0;
      keys = '0; keys[8] = 1'b1; keys[10] = 1'b1;
      repeat (50) step();
      keys[10] = 1'b0;
      repeat (50) step();
      check("k79_pulses", 32'(pulses),    32'd1);
      check("k79_code",   32'(last_code), 32'b0_0111);
      check("k79_down",   32'(key_down),  32'd1);
      keys = '0;
      repeat (40) step();
      check("k79_after", 32'(pulses), 32'd1);

      // 5-cycle glitch on key 5 starting at the first cycle of the row-1 slot.
      pulses = 0;
      found  = 0;
      for (int i = 0; i < 200 && found == 0; i++) begin
         if (m_phase == 0 && m_ri == 1 && m_slot == 0) found = 1;
         else step();
      end
      check("glitch_sync", 32'(found), 32'd1);
      keys = '0; keys[5] = 1'b1;
      repeat (5) step();
      keys = '0;
      repeat (2) step();
      check("glitch_hold_row", 32'(row), 32'b1101);
      step();
      check("glitch_next_row", 32'(row), 32'b1011);
      repeat (30) step();
      check("glitch_pulses", 32'(pulses), 32'd0);

      // Reset during press debounce on key 8, key kept held.
      keys = '0; keys[9] = 1'b1;
      found = 0;
      for (int i = 0; i < 200 && found == 0; i++) begin
         step();
         if (m_phase == 1) found = 1;
      end
      check("rstdeb_sync", 32'(found), 32'd1);
      repeat (2) step();
      pulses = 0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rstdeb_row",    32'(row),       32'b1110);
      check("rstdeb_kv",     32'(key_valid), 32'd0);
      check("rstdeb_kd",     32'(key_down),  32'd0);
      check("rstdeb_tipo",   32'(tipo),      32'd0);
      check("rstdeb_number", 32'(number),    32'd0);
      check("rstdeb_nopulse", 32'(pulses),   32'd0);
      repeat (80) step();
      check("rstdeb_pulses", 32'(pulses),    32'd1);
      check("rstdeb_code",   32'(last_code), 32'b0_1000);
      keys = '0;
      repeat (40) step();

      // Randomized presses, extra keys, bounces and resets.
      for (int it = 0; it < 30; it++) begin
         int k, k2, hold, gap, rst_at, bounce;
         k      = int'($urandom_range(0, 15));
         k2     = int'($urandom_range(0, 15));
         hold   = int'($urandom_range(20, 120));
         gap    = int'($urandom_range(4, 60));
         bounce = ($urandom_range(0, 4) == 0) ? 1 : 0;
         rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 19)) : -1;
         keys = '0; keys[k] = 1'b1;
         if ($urandom_range(0, 3) == 0) keys[k2] = 1'b1;
         for (int t = 0; t < hold; t++) begin
            if (bounce != 0 && t < 12 && (t % 3) == 2) keys[k] = ~keys[k];
            reset = (t == rst_at);
            step();
         end
         reset = 1'b0;
         keys  = '0;
         repeat (gap) step();
      end
      repeat (40) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
